// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - shared types and I2C register map for the Wishbone command master
package wb_cmd_pkg;

  localparam int unsigned REQ_ADDR_WIDTH = 2;
  localparam int unsigned REQ_DATA_WIDTH = 8;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;
  localparam logic [1:0] REG_FSMR = 2'd3;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_POLL     = 2'd2,
    OP_WAIT_IRQ = 2'd3
  } op_t;

  typedef enum logic {
    ST_OK      = 1'b0,
    ST_TIMEOUT = 1'b1
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUS  = 3'd1,
    S_GAP  = 3'd2,
    S_IRQ  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  typedef struct packed {
    op_t                       op;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [REQ_DATA_WIDTH-1:0] mask;
  } req_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// rtl/wb_cmd_fifo.sv - synchronous request FIFO; pointers carry an extra wrap bit for full/empty
module wb_cmd_fifo
  import wb_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = req_t
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - queued Wishbone command engine (write/read/poll/wait-irq) for the I2C register file
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned POLL_GAP       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [DATA_WIDTH-1:0] req_mask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_status_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  irq_i,
  output logic                  busy_o
);

  typedef struct packed {
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] mask;
  } cmd_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  state_t                state;
  cmd_t                  cur;
  cmd_t                  head;
  cmd_t                  push_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  ready_en;
  logic [TW-1:0]         tmo_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] last_rd;
  logic                  expire;
  logic                  poll_hit;

  assign push_req = '{op: op_t'(req_op_i), addr: req_addr_i, data: req_data_i, mask: req_mask_i};

  // ready_en keeps req_ready_o low until the first clock after reset release
  assign req_ready_o = ready_en && !fifo_full;
  assign fifo_push   = req_valid_i && req_ready_o;
  assign fifo_pop    = (state == S_IDLE) && !fifo_empty;
  assign busy_o      = (state != S_IDLE) || !fifo_empty;

  // expire marks the TIMEOUT_CYCLES-th active cycle so the abort decision lands inside the budget
  assign expire   = (tmo_cnt >= TMO_LAST);
  assign poll_hit = ((dat_i ^ cur.data) & cur.mask) == '0;

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .wdata_i (push_req),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cur          <= '0;
      ready_en     <= 1'b0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      last_rd      <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_status_o <= ST_OK;
    end else begin
      ready_en <= 1'b1;
      if ((state inside {S_BUS, S_GAP, S_IRQ}) && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur     <= head;
            tmo_cnt <= '0;
            last_rd <= '0;
            if (head.op == OP_WAIT_IRQ) begin
              state <= S_IRQ;
            end else begin
              state <= S_BUS;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= (head.op == OP_WRITE);
              adr_o <= head.addr;
              dat_o <= (head.op == OP_WRITE) ? head.data : '0;
            end
          end
        end

        S_BUS: begin
          if (ack_i || expire) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
          end
          if (ack_i) begin
            if (cur.op == OP_WRITE) begin
              rsp_valid_o  <= 1'b1;
              rsp_data_o   <= cur.data;
              rsp_status_o <= ST_OK;
              state        <= S_RESP;
            end else begin
              last_rd <= dat_i;
              if ((cur.op == OP_READ) || poll_hit) begin
                rsp_valid_o  <= 1'b1;
                rsp_data_o   <= dat_i;
                rsp_status_o <= ST_OK;
                state        <= S_RESP;
              end else if (expire) begin
                rsp_valid_o  <= 1'b1;
                rsp_data_o   <= dat_i;
                rsp_status_o <= ST_TIMEOUT;
                state        <= S_RESP;
              end else begin
                gap_cnt <= GAP_LAST;
                state   <= S_GAP;
              end
            end
          end else if (expire) begin
            rsp_valid_o  <= 1'b1;
            rsp_data_o   <= last_rd;
            rsp_status_o <= ST_TIMEOUT;
            state        <= S_RESP;
          end
        end

        S_GAP: begin
          if (expire) begin
            rsp_valid_o  <= 1'b1;
            rsp_data_o   <= last_rd;
            rsp_status_o <= ST_TIMEOUT;
            state        <= S_RESP;
          end else if (gap_cnt == '0) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            adr_o <= cur.addr;
            state <= S_BUS;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        S_IRQ: begin
          if (irq_i) begin
            rsp_valid_o  <= 1'b1;
            rsp_data_o   <= '0;
            rsp_status_o <= ST_OK;
            state        <= S_RESP;
          end else if (expire) begin
            rsp_valid_o  <= 1'b1;
            rsp_data_o   <= last_rd;
            rsp_status_o <= ST_TIMEOUT;
            state        <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_status_o <= ST_OK;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - scoreboard bench for wb_cmd_master with a latency-programmable Wishbone slave
module tb_wb_cmd_master;
  import wb_cmd_pkg::*;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int GAP   = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          status;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic [DW-1:0] req_mask_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_status_o;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          irq_i = 1'b0;
  logic          busy_o;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic          bus_we_q[$];
  logic [AW-1:0] bus_adr_q[$];
  logic [DW-1:0] bus_dat_q[$];

  int            total = 0;
  int            bad = 0;
  int            cyc_cnt = 0;
  int            push_cyc = 0;
  int            rsp_cyc = 0;
  logic          rsp_cyc_o = 1'b0;
  int            slave_lat = 0;
  int            wait_cnt = 0;
  logic [DW-1:0] slave_dflt = '0;
  int            cyc_hi_n = 0;
  int            idle_run = 0;
  int            min_gap = 999;
  bit            have_prev = 0;
  logic          prev_cyc = 1'b0;

  wb_cmd_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .POLL_GAP       (GAP)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_mask_i   (req_mask_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_status_o (rsp_status_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .ack_i        (ack_i),
    .irq_i        (irq_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Wishbone slave and bus activity monitor
  initial begin : slave
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (cyc_o) begin
        cyc_hi_n++;
        if (!prev_cyc && have_prev && idle_run < min_gap) min_gap = idle_run;
        have_prev = 1;
        idle_run  = 0;
      end else begin
        idle_run++;
      end
      prev_cyc = cyc_o;
      if (ack_i) begin
        ack_i    = 1'b0;
        wait_cnt = 0;
      end else if (cyc_o && stb_o) begin
        if (wait_cnt >= slave_lat) begin
          ack_i = 1'b1;
          if (rd_q.size() > 0) dat_i = rd_q.pop_front();
          else dat_i = slave_dflt;
          bus_we_q.push_back(we_o);
          bus_adr_q.push_back(adr_o);
          bus_dat_q.push_back(dat_o);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response scoreboard
  initial begin : collector
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_cyc   = cyc_cnt;
        rsp_cyc_o = cyc_o;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_extra: got data=%h status=%0d, required no response", rsp_data_o, rsp_status_o);
        end else begin
          e = exp_q.pop_front();
          if (rsp_data_o !== e.data || rsp_status_o !== e.status) begin
            bad++;
            $display("FAIL rsp_match: got data=%h status=%0d, required data=%h status=%0d",
                     rsp_data_o, rsp_status_o, e.data, e.status);
          end
        end
      end
    end
  end

  task automatic clear_logs;
    bus_we_q.delete();
    bus_adr_q.delete();
    bus_dat_q.delete();
    have_prev = 0;
    min_gap   = 999;
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [DW-1:0] mask, input logic [DW-1:0] exp_data, input logic exp_status);
    int   n = 0;
    exp_t e;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_data_i  = data;
    req_mask_i  = mask;
    while (!req_ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    total++;
    if (!req_ready_o) begin
      bad++;
      $display("FAIL req_accept: ready=%0b after %0d cycles, required 1", req_ready_o, n);
      req_valid_i = 1'b0;
    end else begin
      e.data   = exp_data;
      e.status = exp_status;
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      push_cyc    = cyc_cnt;
      req_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    ok = (exp_q.size() == 0) && !busy_o;
  endtask

  task automatic test_reset;
    #1 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_data_o, rsp_status_o, req_ready_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_data_o, rsp_status_o, req_ready_o, busy_o});
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_early: got %0b, required 0", req_ready_o);
    end
    @(negedge clk_i);
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_late: got %0b, required 1", req_ready_o);
    end
  endtask

  task automatic test_write;
    bit ok;
    clear_logs();
    slave_lat = 2;
    send(OP_WRITE, REG_CMDR, 8'h04, 8'h00, 8'h04, ST_OK);
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (bus_adr_q.size() != 1) begin bad++; $display("FAIL write_bus_count: got %0d, required 1", bus_adr_q.size()); end
    total++;
    if (bus_adr_q.size() == 0 || {bus_we_q[0], bus_adr_q[0], bus_dat_q[0]} !== {1'b1, REG_CMDR, 8'h04}) begin
      bad++;
      $display("FAIL write_bus_fields: got %0d entries, required we=1 adr=2 dat=04", bus_adr_q.size());
    end
  endtask

  task automatic test_read;
    bit ok;
    clear_logs();
    slave_lat = 1;
    rd_q.push_back(8'h30);
    send(OP_READ, REG_FSMR, 8'h00, 8'h00, 8'h30, ST_OK);
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL read_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (bus_adr_q.size() != 1) begin bad++; $display("FAIL read_bus_count: got %0d, required 1", bus_adr_q.size()); end
    total++;
    if (bus_adr_q.size() == 0 || {bus_we_q[0], bus_adr_q[0]} !== {1'b0, REG_FSMR}) begin
      bad++;
      $display("FAIL read_bus_fields: got %0d entries, required we=0 adr=3", bus_adr_q.size());
    end
  endtask

  task automatic test_poll;
    bit ok;
    clear_logs();
    slave_lat = 1;
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h84);
    send(OP_POLL, REG_CMDR, 8'h80, 8'h80, 8'h84, ST_OK);
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL poll_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (bus_adr_q.size() != 3) begin bad++; $display("FAIL poll_bus_count: got %0d, required 3", bus_adr_q.size()); end
    total++;
    if (min_gap < GAP) begin bad++; $display("FAIL poll_gap: got %0d idle cycles, required >= %0d", min_gap, GAP); end
  endtask

  task automatic test_timeout;
    bit ok;
    clear_logs();
    slave_lat  = 0;
    slave_dflt = 8'h11;
    send(OP_POLL, REG_CSR, 8'h80, 8'h80, 8'h11, ST_TIMEOUT);
    wait_drain(200, ok);
    slave_dflt = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL tmo_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (rsp_cyc - push_cyc != TMO + 1) begin
      bad++;
      $display("FAIL tmo_latency: got %0d cycles from push, required %0d", rsp_cyc - push_cyc, TMO + 1);
    end
    total++;
    if (rsp_cyc_o !== 1'b0) begin bad++; $display("FAIL tmo_cyc_drop: got cyc_o=%0b, required 0", rsp_cyc_o); end
  endtask

  task automatic test_irq;
    bit ok;
    int base;
    int irq_cyc;
    base  = cyc_hi_n;
    irq_i = 1'b0;
    send(OP_WAIT_IRQ, REG_DPR, 8'h00, 8'h00, 8'h00, ST_OK);
    repeat (10) @(posedge clk_i);
    #1;
    irq_i   = 1'b1;
    irq_cyc = cyc_cnt;
    wait_drain(200, ok);
    irq_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL irq_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (rsp_cyc - irq_cyc != 1) begin bad++; $display("FAIL irq_latency: got %0d, required 1", rsp_cyc - irq_cyc); end
    irq_i = 1'b1;
    send(OP_WAIT_IRQ, REG_DPR, 8'h00, 8'h00, 8'h00, ST_OK);
    wait_drain(200, ok);
    irq_i = 1'b0;
    total++;
    if (!ok || rsp_cyc - push_cyc != 2) begin
      bad++;
      $display("FAIL irq_preset: got ok=%0b latency=%0d, required ok=1 latency=2", ok, rsp_cyc - push_cyc);
    end
    total++;
    if (cyc_hi_n != base) begin bad++; $display("FAIL irq_no_bus: got %0d cyc cycles, required 0", cyc_hi_n - base); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_logs();
    slave_lat   = 0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_q.push_back(DW'(8'hA1 + i));
    end
    for (int i = 0; i < 5; i++) begin
      send(OP_READ, AW'(i), 8'h00, 8'h00, DW'(8'hA1 + i), ST_OK);
    end
    total++;
    if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_full: got ready=%0b busy=%0b, required ready=0 busy=1", req_ready_o, busy_o);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    wait_drain(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
    total++;
    if (bus_adr_q.size() != 5) begin bad++; $display("FAIL b2b_bus_count: got %0d, required 5", bus_adr_q.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n = 0;
    clear_logs();
    rd_q.delete();
    slave_lat = 50;
    send(OP_READ, REG_DPR, 8'h00, 8'h00, 8'h00, ST_OK);
    send(OP_WRITE, REG_CSR, 8'h55, 8'h00, 8'h55, ST_OK);
    while (!cyc_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    total++;
    if (cyc_o !== 1'b1) begin bad++; $display("FAIL rstmid_cyc_start: got %0b, required 1", cyc_o); end
    rst_n_i = 1'b0;
    #1;
    total++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_cyc_drop: got cyc=%0b stb=%0b, required 0/0", cyc_o, stb_o);
    end
    total++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_empty: got busy=%0b rsp_valid=%0b, required 0/0", busy_o, rsp_valid_o);
    end
    exp_q.delete();
    slave_lat = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %0b, required 1", req_ready_o); end
    rd_q.push_back(8'h5A);
    send(OP_READ, REG_CMDR, 8'h00, 8'h00, 8'h5A, ST_OK);
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_after: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_timeout();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
